// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered 1-cycle read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]       r_w_ptr;
    logic [ADDR_W:0]       r_r_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // The extra pointer MSB distinguishes a full FIFO from an empty one at equal addresses.
    assign w_full   = (r_w_ptr[ADDR_W] != r_r_ptr[ADDR_W]) &&
                      (r_w_ptr[ADDR_W-1:0] == r_r_ptr[ADDR_W-1:0]);
    assign w_empty  = (r_w_ptr == r_r_ptr);
    assign w_wr_acc = w_en && !w_full;
    assign w_rd_acc = r_en && !w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_w_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_ptr     <= '0;
            r_r_ptr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_w_ptr <= r_w_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_r_ptr <= r_r_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= w_en && w_full;
            r_underflow <= r_en && w_empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is exposed directly; meaningless while empty.
    assign data_out = r_mem[r_r_ptr[ADDR_W-1:0]];
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[r_r_ptr[ADDR_W-1:0]];
        end
    end

    assign data_out = r_data_out;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= CNT_W'(AFULL_THRESH));
    assign almost_empty = (r_count <= CNT_W'(AEMPTY_THRESH));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: directed phases plus randomized traffic
// compared against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    sync_fifo_flags #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL),
        .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .data_in     (data_in),
        .r_en        (r_en),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_step = 0;

    // Reference model: a queue of stored words plus the expected registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check("count",        32'(count),        32'(sz));
        check("full",         32'(full),         32'(sz == DEPTH));
        check("empty",        32'(empty),        32'(sz == 0));
        check("almost_full",  32'(almost_full),  32'(sz >= AFULL));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AEMPTY));
        check("overflow",     32'(overflow),     32'(exp_ovf));
        check("underflow",    32'(underflow),    32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (sz > 0) check("data_out", 32'(data_out), 32'(q[0]));
`else
        check("data_out",     32'(data_out),     32'(exp_dout));
`endif
    endtask

    // One clock of traffic: drive, let the edge happen, advance the model, compare.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        int sz;
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        sz      = q.size();
        exp_ovf = w && (sz == DEPTH);
        exp_unf = r && (sz == 0);
        if (r && sz > 0) exp_dout = q.pop_front();
        if (w && sz < DEPTH) q.push_back(d);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        n_step++;
        check_all();
        $display("step %0d: w=%0b r=%0b din=%02h -> dout=%02h cnt=%0d f=%0b e=%0b af=%0b ae=%0b ovf=%0b unf=%0b",
                 n_step, w, r, d, data_out, count, full, empty, almost_full, almost_empty,
                 overflow, underflow);
    endtask

    task automatic check_reset_state();
        check("rst_count",        32'(count),        32'(0));
        check("rst_empty",        32'(empty),        32'(1));
        check("rst_full",         32'(full),         32'(0));
        check("rst_almost_empty", 32'(almost_empty), 32'(1));
        check("rst_almost_full",  32'(almost_full),  32'(0));
        check("rst_overflow",     32'(overflow),     32'(0));
        check("rst_underflow",    32'(underflow),    32'(0));
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_data_out",     32'(data_out),     32'(0));
`endif
        $display("reset check: dout=%02h cnt=%0d e=%0b ae=%0b", data_out, count, empty, almost_empty);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted mid-stream with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'hC0 + i));
        check("pre_rst_count", 32'(count), 32'(5));
        rst = 1'b1;
        #1;
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 8'h00);
        check("first_after_rst", 32'(data_out), 32'(8'h33));

        // Fill 0x00..0x0F, then overflow and simultaneous access at full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        check("filled_full", 32'(full), 32'(1));
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hAB);
        check("full_rw_count", 32'(count), 32'(15));
        step(1'b1, 1'b0, 8'h10);

        // Drain, then underflow on an empty FIFO.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        check("drained_empty", 32'(empty), 32'(1));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b1, 8'h00);

        // Hold occupancy at eight with concurrent reads and writes; pointers wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'(8'h50 + i));
        check("steady_count", 32'(count), 32'(8));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);

`ifdef SYNC_FIFO_FWFT_EN
        step(1'b1, 1'b0, 8'h5A);
        check("fwft_head", 32'(data_out), 32'(8'h5A));
        step(1'b1, 1'b0, 8'h6B);
        step(1'b0, 1'b1, 8'h00);
        check("fwft_next", 32'(data_out), 32'(8'h6B));
        step(1'b0, 1'b1, 8'h00);
        check("fwft_empty", 32'(empty), 32'(1));
`endif

        // Randomized traffic in phases biased toward filling, draining or balance.
        for (int ph = 0; ph < 12; ph++) begin
            int pw;
            pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 30; i++) begin
                step(($urandom_range(99) < pw), ($urandom_range(99) < 100 - pw),
                     DW'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
